// File: rtl/hazard_scheduler.sv
// hazard_scheduler: load-use / MDU hazard detection and pipeline control for a 5-stage MIPS-like core.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
`default_nettype none

module hazard_scheduler #(
    parameter int unsigned MDU_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_branch_taken,
    input  logic        id_is_mdu,
    input  logic        id_reads_hilo,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [15:0] stall_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MDU_LATENCY - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mdu_busy_q;

    logic load_use;
    logic mdu_stall;
    logic stall;

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    assign mdu_stall = (state_q == MDU_WAIT) && (cnt_q != 4'd0) &&
                       (id_is_mdu || id_reads_hilo);

    assign stall       = load_use || mdu_stall;
    assign pc_hold     = stall;
    assign ifid_hold   = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = id_branch_taken && !stall;
    assign mdu_start   = id_is_mdu && !stall;
    assign mdu_busy    = mdu_busy_q;

    // The countdown keeps running during stalls; a new MDU op can only issue once cnt reaches 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mdu_start) begin
            state_d = MDU_WAIT;
            cnt_d   = CNT_LOAD;
        end else if (state_q == MDU_WAIT) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= 4'd0;
            mdu_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdu_busy_q <= (state_d == MDU_WAIT);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= 16'h0000;
        end else if (pc_hold && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed and randomized checks of hazard_scheduler against a cycle-window reference model.
`default_nettype none

module tb_hazard_scheduler;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_branch_taken, id_is_mdu, id_reads_hilo, ex_memread;
    logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, mdu_start, mdu_busy;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_scheduler #(.MDU_LATENCY(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_branch_taken(id_branch_taken),
        .id_is_mdu      (id_is_mdu),
        .id_reads_hilo  (id_reads_hilo),
        .ex_memread     (ex_memread),
        .ex_rd          (ex_rd),
        .pc_hold        (pc_hold),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .mdu_start      (mdu_start),
        .mdu_busy       (mdu_busy),
        .stall_count    (stall_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the MDU is described by the cycle index of its last launch.
    // It is busy for cycles (start, start+LAT] and blocks MDU/HI-LO readers for (start, start+LAT).
    bit     mdu_valid = 1'b0;
    longint last_start = 0;
    longint cyc = 0;
    int     sc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                        input bit br, input bit mdu, input bit hilo, input bit mr, input logic [4:0] rd);
        bit lu, win, busy, st;
        int exp_sc;
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_branch_taken = br; id_is_mdu = mdu; id_reads_hilo = hilo;
        ex_memread = mr; ex_rd = rd;
        #1;
        lu   = mr && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
        win  = mdu_valid && (cyc > last_start) && (cyc < last_start + LAT);
        busy = mdu_valid && (cyc > last_start) && (cyc <= last_start + LAT);
        st   = lu || (win && (mdu || hilo));
`ifdef HAZARD_STALL_CNT_EN
        exp_sc = sc;
`else
        exp_sc = 0;
`endif
        check("pc_hold",     {31'd0, pc_hold},     {31'd0, st});
        check("ifid_hold",   {31'd0, ifid_hold},   {31'd0, st});
        check("idex_bubble", {31'd0, idex_bubble}, {31'd0, st});
        check("ifid_flush",  {31'd0, ifid_flush},  {31'd0, br && !st});
        check("mdu_start",   {31'd0, mdu_start},   {31'd0, mdu && !st});
        check("mdu_busy",    {31'd0, mdu_busy},    {31'd0, busy});
        check("stall_count", {16'd0, stall_count}, exp_sc);
        if (!rst) begin
            if (mdu && !st) begin
                mdu_valid  = 1'b1;
                last_start = cyc;
            end
            if (st && sc < 65535) sc++;
        end
        cyc++;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nb, ns;
        logic [4:0] rs, rt, rd;
        rst = 1'b1;
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_branch_taken = 0;
        id_is_mdu = 0; id_reads_hilo = 0; ex_memread = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy",  {31'd0, mdu_busy}, 32'd0);
        check("reset_count", {16'd0, stall_count}, 32'd0);
        check("reset_hold",  {31'd0, pc_hold}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load-use hazard on rs, then the same with ex_rd = 0.
        step(5'd8, 5'd0, 1, 0, 0, 0, 0, 1, 5'd8);
        check("lu_stall", {31'd0, pc_hold}, 32'd1);
        idle();
        check("lu_release", {31'd0, pc_hold}, 32'd0);
        step(5'd8, 5'd0, 1, 0, 0, 0, 0, 1, 5'd0);
        check("lu_rd0", {31'd0, pc_hold}, 32'd0);
        step(5'd0, 5'd0, 1, 1, 0, 0, 0, 1, 5'd0);

        // mult followed by a held mfhi.
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0);
        check("mdu_launch", {31'd0, mdu_start}, 32'd1);
        nb = 0; ns = 0;
        for (int i = 0; i < 6; i++) begin
            step(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'd0);
            nb += int'(mdu_busy);
            ns += int'(pc_hold);
        end
        check("busy_cycles",  nb, 32'd4);
        check("stall_cycles", ns, 32'd3);

        // Back-to-back issue when the countdown reaches zero.
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0);
        repeat (3) idle();
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0);
        check("b2b_start", {31'd0, mdu_start}, 32'd1);
        check("b2b_busy",  {31'd0, mdu_busy},  32'd1);
        repeat (3) step(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'd0);
        repeat (3) idle();

        // Taken branch held off by a load-use stall.
        step(5'd3, 5'd5, 0, 1, 1, 0, 0, 1, 5'd5);
        check("br_stalled", {31'd0, ifid_flush}, 32'd0);
        step(5'd3, 5'd5, 0, 1, 1, 0, 0, 0, 5'd5);
        check("br_flush", {31'd0, ifid_flush}, 32'd1);

        // Asynchronous reset while cnt == 2.
        step(5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0);
        idle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        mdu_valid = 1'b0;
        sc = 0;
        #1;
        check("rst_busy",  {31'd0, mdu_busy}, 32'd0);
        check("rst_count", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'd0);
        check("rst_run", {31'd0, pc_hold}, 32'd0);

        // Randomized traffic with small register numbers to provoke collisions.
        repeat (600) begin
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            step(rs, rt, ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 5) == 0,
                 ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0, rd);
        end

`ifdef HAZARD_STALL_CNT_EN
        repeat (70000) step(5'd9, 5'd0, 1, 0, 0, 0, 0, 1, 5'd9);
        check("count_sat", {16'd0, stall_count}, 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
